// File: rtl/rv32i_pkg.sv
// Shared RV32I opcode/func3 constants and the MEM-stage FSM state type.
// Optional build macro MEM_TIMEOUT_EN enables the dmem timeout abort in rv32i_memtop.
package rv32i_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/rv32i_mem_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational so a future fetch path can reuse it.
module rv32i_mem_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = load_word >> {offset, 3'b000};

        case (func3[1:0])
            2'b00: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << offset;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase

        case (func3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/rv32i_memtop.sv
// RV32I memory-access stage: req/ack data bus, stall generation, writeback bundle.
// Define MEM_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES and add the bus_err port.
module rv32i_memtop
    import rv32i_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] iw_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] rs2_data_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_reg_in,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] iw_out,
    output logic [31:0] alu_out,
    output logic        wb_en_out,
    output logic [4:0]  wb_reg_out,
    output logic        misalign_err,
`ifdef MEM_TIMEOUT_EN
    output logic        bus_err,
`endif
    output logic        df_mem_enable,
    output logic [4:0]  df_mem_reg,
    output logic [31:0] df_mem_data
);

    mem_state_t  state_q, state_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        valid_q, valid_d, wb_en_q, wb_en_d, mis_q, mis_d;
    logic [31:0] pc_q, pc_d, iw_q, iw_d, alu_q, alu_d;
    logic [4:0]  wb_reg_q, wb_reg_d;

    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        is_load, is_store, is_mem, misaligned, wb_ok;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, load_data;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
`endif

    assign opcode = iw_in[6:0];
    assign func3  = iw_in[14:12];

    always_comb begin
        is_load    = (opcode == OP_LOAD) && (func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        is_store   = (opcode == OP_STORE) && (func3 inside {F3_B, F3_H, F3_W});
        is_mem     = valid_in && (is_load || is_store);
        misaligned = ((func3[1:0] == 2'b01) && alu_in[0]) ||
                     ((func3[1:0] == 2'b10) && (alu_in[1:0] != 2'b00));
        wb_ok      = wb_en_in && (wb_reg_in != 5'd0);
    end

    rv32i_mem_align u_align (
        .func3      (func3),
        .offset     (alu_in[1:0]),
        .store_data (rs2_data_in),
        .load_word  (dmem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (load_data)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        valid_d   = valid_q;
        pc_d      = pc_q;
        iw_d      = iw_q;
        alu_d     = alu_q;
        wb_en_d   = wb_en_q;
        wb_reg_d  = wb_reg_q;
        mis_d     = 1'b0;
        mem_stall = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d     = cnt_q;
        bus_err_d = 1'b0;
`endif
        case (state_q)
            ST_ACCESS: begin
                // Upstream is frozen by the stall, so the bundle is taken live from the inputs.
                mem_stall = !dmem_ack;
                if (dmem_ack) begin
                    state_d  = ST_IDLE;
                    req_d    = 1'b0;
                    valid_d  = 1'b1;
                    pc_d     = pc_in;
                    iw_d     = iw_in;
                    wb_reg_d = wb_reg_in;
                    alu_d    = is_load ? load_data : alu_in;
                    wb_en_d  = is_load && wb_ok;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    mem_stall = 1'b0;
                    state_d   = ST_IDLE;
                    req_d     = 1'b0;
                    valid_d   = 1'b1;
                    pc_d      = pc_in;
                    iw_d      = iw_in;
                    wb_reg_d  = wb_reg_in;
                    alu_d     = alu_in;
                    wb_en_d   = 1'b0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                pc_d     = pc_in;
                iw_d     = iw_in;
                wb_reg_d = wb_reg_in;
                alu_d    = alu_in;
                if (is_mem && !misaligned) begin
                    mem_stall = 1'b1;
                    state_d   = ST_ACCESS;
                    req_d     = 1'b1;
                    we_d      = is_store;
                    addr_d    = {alu_in[31:2], 2'b00};
                    be_d      = lane_be;
                    wdata_d   = is_store ? lane_wdata : 32'h0;
                    valid_d   = 1'b0;
                    wb_en_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end else begin
                    valid_d = valid_in;
                    wb_en_d = wb_ok && !is_store && !(is_load && misaligned);
                    mis_d   = is_mem && misaligned;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            valid_q   <= 1'b0;
            pc_q      <= '0;
            iw_q      <= '0;
            alu_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_reg_q  <= '0;
            mis_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            iw_q      <= iw_d;
            alu_q     <= alu_d;
            wb_en_q   <= wb_en_d;
            wb_reg_q  <= wb_reg_d;
            mis_q     <= mis_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
`endif
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_be       = be_q;
    assign dmem_wdata    = wdata_q;
    assign valid_out     = valid_q;
    assign pc_out        = pc_q;
    assign iw_out        = iw_q;
    assign alu_out       = alu_q;
    assign wb_en_out     = wb_en_q;
    assign wb_reg_out    = wb_reg_q;
    assign misalign_err  = mis_q;
`ifdef MEM_TIMEOUT_EN
    assign bus_err       = bus_err_q;
`endif
    assign df_mem_enable = wb_en_q & valid_q;
    assign df_mem_reg    = wb_reg_q;
    assign df_mem_data   = alu_q;

endmodule

// File: tb/tb_rv32i_memtop.sv
// Scoreboard bench for rv32i_memtop: driver queues expected bus requests and
// writeback bundles, a bus responder and an output monitor check them independently.
module tb_rv32i_memtop;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] pc_in, iw_in, alu_in, rs2_data_in;
    logic        wb_en_in;
    logic [4:0]  wb_reg_in;
    logic        mem_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        valid_out;
    logic [31:0] pc_out, iw_out, alu_out;
    logic        wb_en_out;
    logic [4:0]  wb_reg_out;
    logic        misalign_err, df_mem_enable;
    logic [4:0]  df_mem_reg;
    logic [31:0] df_mem_data;

    rv32i_memtop dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in), .iw_in(iw_in),
        .alu_in(alu_in), .rs2_data_in(rs2_data_in), .wb_en_in(wb_en_in), .wb_reg_in(wb_reg_in),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .valid_out(valid_out), .pc_out(pc_out), .iw_out(iw_out), .alu_out(alu_out),
        .wb_en_out(wb_en_out), .wb_reg_out(wb_reg_out), .misalign_err(misalign_err),
        .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, iw, alu;
        logic        wb_en;
        logic [4:0]  rd;
        logic        mis;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  be;
        logic        we, chk_be;
        int          delay;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   resp_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on the ISA rules.
    function automatic bit model_is_load(input logic [31:0] iw);
        return iw[6:0] == 7'h03 && (iw[14:12] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    endfunction

    function automatic bit model_is_store(input logic [31:0] iw);
        return iw[6:0] == 7'h23 && (iw[14:12] inside {3'd0, 3'd1, 3'd2});
    endfunction

    function automatic int model_bytes(input logic [31:0] iw);
        if (iw[13:12] == 2'd0) return 1;
        if (iw[13:12] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] word);
        int unsigned v, n;
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        v = word >> (8 * off);
        if (n == 1) v = v % 256;
        if (n == 2) v = v % 65536;
        if (!f3[2] && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    function automatic logic [31:0] model_lanes(input logic [31:0] rs2, input int n);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % n) +: 8];
        return w;
    endfunction

    // Drives one execute bundle, queues expectations, and holds it while stalled.
    task automatic do_op(input logic vld, input logic [31:0] iw, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic wb, input logic [4:0] rd,
                         input logic [31:0] rdata, input int delay);
        bit   ld, st, mem, al;
        int   n, off, exp_stall, stalls;
        exp_t e;
        req_t r;
        logic [31:0] pc;
        pc  = $urandom;
        ld  = model_is_load(iw);
        st  = model_is_store(iw);
        n   = model_bytes(iw);
        off = int'(alu[1:0]);
        al  = (off % n) == 0;
        mem = vld && (ld || st);
        valid_in = vld; pc_in = pc; iw_in = iw; alu_in = alu;
        rs2_data_in = rs2; wb_en_in = wb; wb_reg_in = rd;
        e.pc = pc; e.iw = iw; e.rd = rd; e.alu = alu; e.mis = 1'b0;
        e.wb_en = wb && (rd != 5'd0);
        exp_stall = 0;
        if (mem && !al) begin
            e.mis = 1'b1;
            e.wb_en = 1'b0;
        end else if (mem) begin
            r.addr   = alu - 32'(off);
            r.be     = 4'(((1 << n) - 1) << off);
            r.chk_be = st || (n == 4);
            r.we     = st;
            r.wdata  = model_lanes(rs2, n);
            r.rdata  = rdata;
            r.delay  = delay;
            req_q.push_back(r);
            exp_stall = delay + 1;
            if (ld) e.alu = model_load(iw[14:12], off, rdata);
            else    e.wb_en = 1'b0;
        end
        e.cyc = cyc + exp_stall + 1;
        if (vld) exp_q.push_back(e);
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!mem_stall) break;
            stalls++;
            if (stalls > 40) begin
                chk("stall_bound", 32'(stalls), 32'(exp_stall));
                break;
            end
        end
        if (stalls <= 40) chk("stall_cycles", 32'(stalls), 32'(exp_stall));
        @(posedge clk); #1;
    endtask

    // Data-memory responder: checks each request and acks after its scripted delay.
    initial begin
        req_t r;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (resp_en && dmem_req) begin
                if (req_q.size() == 0) begin
                    chk("dmem_req_unexpected", 32'(dmem_req), 32'd0);
                end else begin
                    r = req_q.pop_front();
                    chk("dmem_addr", dmem_addr, r.addr);
                    chk("dmem_we", 32'(dmem_we), 32'(r.we));
                    if (r.chk_be) chk("dmem_be", 32'(dmem_be), 32'(r.be));
                    if (r.we) chk("dmem_wdata", dmem_wdata, r.wdata);
                    for (int k = 0; k < r.delay; k++) begin
                        @(posedge clk); #2;
                        chk("req_held", 32'(dmem_req), 32'd1);
                        chk("addr_held", dmem_addr, r.addr);
                        if (r.we) chk("wdata_held", dmem_wdata, r.wdata);
                    end
                    dmem_ack = 1'b1;
                    dmem_rdata = r.rdata;
                    @(posedge clk); #2;
                    dmem_ack = 1'b0;
                    dmem_rdata = $urandom;
                    chk("req_drop", 32'(dmem_req), 32'd0);
                end
            end
        end
    end

    // Output monitor: every valid_out pops one expected bundle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("valid_out_unexpected", 32'(valid_out), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_cycle", 32'(cyc), 32'(e.cyc));
                    chk("pc_out", pc_out, e.pc);
                    chk("iw_out", iw_out, e.iw);
                    chk("alu_out", alu_out, e.alu);
                    chk("wb_en_out", 32'(wb_en_out), 32'(e.wb_en));
                    chk("wb_reg_out", 32'(wb_reg_out), 32'(e.rd));
                    chk("misalign_err", 32'(misalign_err), 32'(e.mis));
                    chk("df_mem_enable", 32'(df_mem_enable), 32'(e.wb_en));
                    chk("df_mem_reg", 32'(df_mem_reg), 32'(e.rd));
                    chk("df_mem_data", df_mem_data, e.alu);
                end
            end else if (misalign_err) begin
                chk("misalign_without_valid", 32'(misalign_err), 32'd0);
            end
        end
    end

    localparam logic [31:0] IW_LW  = 32'h0000_2283;
    localparam logic [31:0] IW_LB  = 32'h0000_0283;
    localparam logic [31:0] IW_LBU = 32'h0000_4283;
    localparam logic [31:0] IW_SH  = 32'h0000_1023;
    localparam logic [31:0] IW_ADD = 32'h0000_02B3;

    initial begin
        logic [31:0] iw;
        logic [6:0]  op;
        int          sel;
        valid_in = 1'b0; pc_in = '0; iw_in = '0; alu_in = '0;
        rs2_data_in = '0; wb_en_in = 1'b0; wb_reg_in = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_alu_out", alu_out, 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        chk("rst_df_enable", 32'(df_mem_enable), 32'd0);
        chk("rst_mem_stall", 32'(mem_stall), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_pc_out", pc_out, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        do_op(1'b1, IW_LW, 32'h100, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 0);
        do_op(1'b1, IW_LB, 32'h103, 32'h0, 1'b1, 5'd6, 32'h80FFFFFF, 1);
        do_op(1'b1, IW_LBU, 32'h103, 32'h0, 1'b1, 5'd7, 32'h80FFFFFF, 0);
        // Ack arrives 5 cycles after the bundle is presented.
        do_op(1'b1, IW_SH, 32'h202, 32'h1234ABCD, 1'b1, 5'd8, 32'h0, 4);
        do_op(1'b1, IW_LW, 32'h101, 32'h0, 1'b1, 5'd9, 32'h0, 0);
        do_op(1'b1, IW_ADD, 32'h7, 32'h0, 1'b1, 5'd10, 32'h0, 0);
        do_op(1'b1, IW_LW, 32'h104, 32'h0, 1'b1, 5'd0, 32'h1234_5678, 0);

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            op  = (sel < 4) ? 7'h03 : (sel < 7) ? 7'h23 : (sel < 9) ? 7'h33 : 7'($urandom);
            iw  = $urandom;
            iw[6:0] = op;
            iw[14:12] = 3'($urandom_range(0, 7));
            do_op(($urandom_range(0, 9) != 0), iw, $urandom, $urandom, 1'($urandom),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom,
                  $urandom_range(0, 4));
        end
        valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of an access.
        resp_en = 1'b0;
        valid_in = 1'b1; iw_in = IW_LW; alu_in = 32'h300; wb_en_in = 1'b1; wb_reg_in = 5'd3;
        @(posedge clk); #1;
        chk("rst_mid_req_up", 32'(dmem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_req_drop", 32'(dmem_req), 32'd0);
        chk("rst_mid_valid", 32'(valid_out), 32'd0);
        valid_in = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(valid_out), 32'd0);
            chk("post_rst_req", 32'(dmem_req), 32'd0);
        end

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
